ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
- AHB3-Lite slave wrapping a small word-organised register-file SRAM; the target device on the bus whose slave-side response rules the formal properties check.
- Accepts single and burst transfers of byte, halfword and word size, inserts a configurable number of wait states, and returns the two-cycle ERROR response for illegal accesses.
- Sits directly downstream of the AHB3-Lite master or interconnect. Its HREADYOUT is fed back as HREADY in single-slave benches.

Parameters:
- MEM_WORDS, 16, number of 32-bit words; legal byte addresses are 0 .. MEM_WORDS*4-1.
- WAIT_STATES, 1, wait cycles per OKAY data phase. Legal range 0..3, so every OKAY completes within 1..4 cycles of the address phase.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  16  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=halfword, 2=word.
- HBURST  in  3  burst type; ignored functionally (address comes from HADDR each beat).
- HPROT  in  4  ignored.
- HWDATA  in  32  write data, little-endian byte lanes.
- HREADY  in  1  bus ready (previous data phase complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (HRESET=1 at an edge):
  - state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
  - All memory words cleared to 0.
  - Reset mid-transfer aborts the transfer: no write, no error cycle.
- Address phase accept: HSEL & HREADY & HTRANS[1]. On accept, latch HADDR, HSIZE and HWRITE.
  - IDLE/BUSY, or HSEL=0: not accepted; next cycle HREADYOUT=1, HRESP=0.
- Error check at accept (any true gives ERROR): HSIZE>2; HADDR>=MEM_WORDS*4; halfword with HADDR[0]=1; word with HADDR[1:0]!=0.
- FSM states IDLE, WAIT, DATA, ERR1, ERR2. Outputs per state:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0; counter counts down.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - Accept with error -> ERR1, then ERR2.
  - Accept without error, WAIT_STATES=0 -> DATA.
  - Accept without error, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1; WAIT -> DATA when counter=0.
  - From DATA or ERR2: a new accept that same cycle is handled as above; otherwise -> IDLE.
  - In WAIT/ERR1 HREADY is low by protocol; if HREADY is high anyway, no accept occurs.
- Write commit, at the rising edge ending the DATA cycle:
  - Byte lanes enabled per latched size and address: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all four lanes.
  - Only enabled lanes of word HADDR[15:2] are updated from HWDATA.
  - HWDATA is sampled only in DATA; its value in WAIT is don't-care.
- Read data:
  - In DATA, HRDATA = full 32-bit stored word at latched HADDR[15:2] (unmasked; master selects lanes).
  - HRDATA=0 in all other states and for writes.
  - Read of a word written in the immediately preceding data phase returns the new value.
- Error handling:
  - No memory access during ERR1/ERR2.
  - A NONSEQ presented during ERR2 with HREADY=1 is accepted normally; a master cancelling with IDLE is also legal.
- Burst handling:
  - SEQ is treated identically to NONSEQ.
  - BUSY inside a burst gives a zero-wait OKAY and no access.
  - Wrap and increment addressing is the master's job.

Test Plan:
- Reset then word write 0xDEADBEEF @0x0004, WAIT_STATES=1 -> HREADYOUT 0 for 1 cycle, then 1 with HRESP=0; subsequent word read @0x0004 returns 0xDEADBEEF in its DATA cycle.
- Byte write 0xAA @0x0005, then halfword write 0x1234 @0x0006, after the word above -> word read @0x0004 returns 0x1234AAEF.
- Word read @0x0002 (misaligned) and word read @0x0040 (out of range, MEM_WORDS=16) -> each gives ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); memory unchanged.
- Back-to-back pipelined NONSEQ write 0x11111111 @0x0 then read @0x0, WAIT_STATES=0 -> HREADYOUT held at 1; read DATA cycle returns 0x11111111.
- IDLE and BUSY cycles with HSEL=1, plus NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, no memory change, HRDATA=0.
- HRESET asserted during WAIT of a word write 0xCAFEF00D @0x8 (WAIT_STATES=3) -> next cycle HREADYOUT=1, HRESP=0; read @0x8 returns 0x00000000.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a word-organised register-file SRAM.
// Supports byte/halfword/word single and burst transfers, a fixed number of
// wait states per OKAY data phase, and the two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int MEM_WORDS   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned NW        = MEM_WORDS;
  localparam logic [16:0] MEM_BYTES = 17'(MEM_WORDS * 4);
  localparam logic [1:0]  WS_LOAD   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    cnt;
  logic [AW-1:0] word_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic          addr_err;
  logic [3:0]    be;
  logic [31:0]   lane_mask;

  // Burst type, protection and the BUSY/IDLE distinction do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HTRANS[0]};

  // Address phase is only sampled in states whose data phase is completing.
  always_comb begin
    accept = 1'b0;
    if (state == S_IDLE || state == S_DATA || state == S_ERR2) begin
      accept = HSEL & HREADY & HTRANS[1];
    end
  end

  // Illegal size, out-of-range address or misalignment yields ERROR.
  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                           addr_err = 1'b1;
    if ({1'b0, HADDR} >= MEM_BYTES)             addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])              addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)   addr_err = 1'b1;
  end

  // State register, wait counter and latched address-phase controls.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_q  <= HADDR[AW+1:2];
        lane_q  <= HADDR[1:0];
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
        cnt     <= WS_LOAD;
      end else if (state == S_WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept)                state_nxt = S_IDLE;
        else if (addr_err)          state_nxt = S_ERR1;
        else if (WAIT_STATES == 0)  state_nxt = S_DATA;
        else                        state_nxt = S_WAIT;
      end
      S_WAIT:  if (cnt == 2'd0) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte-lane enables from the latched size and low address bits.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  // Memory clear on reset; masked write commit at the end of a write DATA cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < NW; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (state == S_DATA && write_q) begin
      mem[word_q] <= (mem[word_q] & ~lane_mask) | (HWDATA & lane_mask);
    end
  end

  // Bus response outputs decoded from state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      S_WAIT:  HREADYOUT = 1'b0;
      S_DATA:  if (!write_q) HRDATA = mem[word_q];
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: three instances (0, 1 and 3 wait states)
// share one bus; only the instance selected by 'cur' sees HSEL.
module tb_ahb3lite_sram_slave;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        hreset;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  int unsigned cur;

  logic        hsel_v [3];
  logic        rdy_v  [3];
  logic        resp_v [3];
  logic [31:0] rd_v   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hsel_v[g] = hsel && (cur == g);
    ahb3lite_sram_slave #(
      .MEM_WORDS  (16),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .HCLK     (clk),
      .HRESET   (hreset),
      .HSEL     (hsel_v[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HPROT    (hprot),
      .HWDATA   (hwdata),
      .HREADY   (hready),
      .HRDATA   (rd_v[g]),
      .HREADYOUT(rdy_v[g]),
      .HRESP    (resp_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: byte-addressed memory per instance, plus the transfer in
  // its data phase and how many cycles of it have elapsed.
  logic [7:0] ref_mem [3][64];
  vec_t       q[$];
  vec_t       dp;
  logic       dp_active;
  logic       dp_err;
  int         dp_cyc;
  logic       force_rdy_en;
  int         checks;
  int         failures;

  function automatic int ws_of(int unsigned k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic is_err(vec_t v);
    int nbytes;
    if (v.size > 3'd2) return 1'b1;
    if (v.addr >= 16'd64) return 1'b1;
    nbytes = 1 << v.size;
    return (int'(v.addr) % nbytes) != 0;
  endfunction

  function automatic logic [31:0] ref_word(logic [15:0] addr);
    int b;
    b = (int'(addr) / 4) * 4;
    return {ref_mem[cur][b+3], ref_mem[cur][b+2], ref_mem[cur][b+1], ref_mem[cur][b]};
  endfunction

  task automatic commit(vec_t v);
    int a;
    int n;
    a = int'(v.addr);
    n = 1 << v.size;
    for (int k = 0; k < n; k++) begin
      ref_mem[cur][a+k] = v.wdata[8*((a+k)%4) +: 8];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 64; j++)
        ref_mem[i][j] = 8'h00;
    dp_active = 1'b0;
    dp_cyc    = 0;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", name, cur, $time, got, exp);
    end
  endtask

  function automatic vec_t mk(logic sel, logic [1:0] tr, logic w, logic [2:0] sz,
                              logic [15:0] ad, logic [31:0] wd, logic c, logic e,
                              logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.write = w; v.size = sz; v.addr = ad;
    v.wdata = wd; v.chk = c; v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  // One bus cycle: check outputs against the model, drive the next address
  // phase, take the rising edge, then advance the model.
  task automatic step();
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rd;
    logic        final_c;
    logic        have_a;
    vec_t        a;
    e_rdy = 1'b1; e_resp = 1'b0; e_rd = '0; final_c = 1'b0;
    if (dp_active) begin
      if (dp_err) begin
        e_resp = 1'b1;
        e_rdy  = (dp_cyc == 1);
      end else begin
        e_rdy = (dp_cyc == ws_of(cur));
        if (e_rdy && !dp.write) e_rd = ref_word(dp.addr);
      end
      final_c = e_rdy;
    end
    check("hreadyout", {31'b0, rdy_v[cur]}, {31'b0, e_rdy});
    check("hresp", {31'b0, resp_v[cur]}, {31'b0, e_resp});
    check("hrdata", rd_v[cur], e_rd);
    if (final_c && dp.chk) begin
      check("tbl_hresp", {31'b0, resp_v[cur]}, {31'b0, dp.exp_err});
      if (!dp.write && !dp.exp_err) check("tbl_hrdata", rd_v[cur], dp.exp_rdata);
    end

    have_a = (q.size() > 0);
    if (have_a) a = q[0];
    else a = mk(1'b0, 2'd0, 1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    hsel   = a.sel;
    htrans = a.trans;
    hwrite = a.write;
    hsize  = a.size;
    haddr  = a.addr;
    hburst = 3'($urandom);
    hprot  = 4'($urandom);
    hwdata = (final_c && !dp_err && dp.write) ? dp.wdata : $urandom;
    hready = e_rdy | (force_rdy_en && ($urandom_range(0, 3) == 0));

    @(posedge clk);
    if (hreset) begin
      clear_model();
    end else begin
      if (final_c && !dp_err && dp.write) commit(dp);
      if (dp_active) begin
        if (final_c) dp_active = 1'b0;
        else dp_cyc++;
      end
      if (e_rdy && have_a) begin
        void'(q.pop_front());
        if (a.sel && a.trans[1]) begin
          dp        = a;
          dp_active = 1'b1;
          dp_cyc    = 0;
          dp_err    = is_err(a);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_all();
    int n;
    n = 0;
    while ((q.size() > 0 || dp_active) && n < 3000) begin
      step();
      n++;
    end
    if (q.size() > 0 || dp_active) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout inst=%0d got=%0d_pending exp=0_pending", cur, q.size());
      q.delete();
      dp_active = 1'b0;
    end
    step();
  endtask

  vec_t tbl [17];

  initial begin
    checks = 0; failures = 0; force_rdy_en = 1'b0; cur = 1;
    dp = mk(1'b0, 2'd0, 1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    dp_err = 1'b0;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
    hburst = '0; hprot = '0; hwdata = '0; hready = 1'b1;

    tbl[0]  = mk(1, 2'd2, 1, 3'd2, 16'h0004, 32'hDEADBEEF, 1, 0, 32'h0);
    tbl[1]  = mk(1, 2'd2, 0, 3'd2, 16'h0004, 32'h0,        1, 0, 32'hDEADBEEF);
    tbl[2]  = mk(1, 2'd2, 1, 3'd0, 16'h0005, 32'h5555AA55, 1, 0, 32'h0);
    tbl[3]  = mk(1, 2'd3, 1, 3'd1, 16'h0006, 32'h12346666, 1, 0, 32'h0);
    tbl[4]  = mk(1, 2'd2, 0, 3'd2, 16'h0004, 32'h0,        1, 0, 32'h1234AAEF);
    tbl[5]  = mk(1, 2'd2, 0, 3'd2, 16'h0002, 32'h0,        1, 1, 32'h0);
    tbl[6]  = mk(1, 2'd2, 0, 3'd2, 16'h0040, 32'h0,        1, 1, 32'h0);
    tbl[7]  = mk(1, 2'd0, 1, 3'd2, 16'h0004, 32'hFFFFFFFF, 0, 0, 32'h0);
    tbl[8]  = mk(1, 2'd1, 1, 3'd2, 16'h0004, 32'hFFFFFFFF, 0, 0, 32'h0);
    tbl[9]  = mk(0, 2'd2, 1, 3'd2, 16'h0004, 32'hFFFFFFFF, 0, 0, 32'h0);
    tbl[10] = mk(1, 2'd2, 0, 3'd2, 16'h0004, 32'h0,        1, 0, 32'h1234AAEF);
    tbl[11] = mk(1, 2'd2, 1, 3'd1, 16'h0001, 32'hFFFFFFFF, 1, 1, 32'h0);
    tbl[12] = mk(1, 2'd2, 0, 3'd3, 16'h0000, 32'h0,        1, 1, 32'h0);
    tbl[13] = mk(1, 2'd2, 1, 3'd0, 16'h003F, 32'h77000000, 1, 0, 32'h0);
    tbl[14] = mk(1, 2'd2, 0, 3'd2, 16'h003C, 32'h0,        1, 0, 32'h77000000);
    tbl[15] = mk(1, 2'd2, 0, 3'd2, 16'h0004, 32'h0,        1, 0, 32'h1234AAEF);
    tbl[16] = mk(1, 2'd2, 0, 3'd2, 16'h0000, 32'h0,        1, 0, 32'h0);

    // Initial reset, then reset-state outputs of every instance.
    hreset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    hreset = 1'b0;
    clear_model();
    for (int unsigned k = 0; k < 3; k++) begin
      cur = k;
      check("reset_hreadyout", {31'b0, rdy_v[k]}, 32'h1);
      check("reset_hresp", {31'b0, resp_v[k]}, 32'h0);
      check("reset_hrdata", rd_v[k], 32'h0);
    end

    // Directed vectors on the 1-wait-state instance, fully pipelined.
    cur = 1;
    for (int i = 0; i < 17; i++) q.push_back(tbl[i]);
    run_all();

    // Zero wait states: back-to-back write then read of the same word.
    cur = 0;
    q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0000, 32'h11111111, 1, 0, 32'h0));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0000, 32'h0, 1, 0, 32'h11111111));
    run_all();

    // Reset during the wait states of a write: no write, response returns to idle.
    cur = 2;
    q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0008, 32'hCAFEF00D, 1, 0, 32'h0));
    step();
    step();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    check("post_reset_hreadyout", {31'b0, rdy_v[2]}, 32'h1);
    check("post_reset_hresp", {31'b0, resp_v[2]}, 32'h0);
    q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0008, 32'h0, 1, 0, 32'h0));
    run_all();

    // Randomised traffic on each instance, including HREADY driven high
    // during cycles the slave is stalling.
    for (int unsigned k = 0; k < 3; k++) begin
      cur = k;
      force_rdy_en = 1'b1;
      for (int n = 0; n < 200; n++) begin
        vec_t v;
        logic [2:0] sz;
        logic [15:0] ad;
        sz = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
        ad = 16'($urandom_range(0, 71));
        if (($urandom % 4) != 0 && sz <= 3'd2) ad = ad & ~16'((1 << sz) - 1);
        v = mk($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz, ad,
               $urandom, 1'b0, 1'b0, 32'h0);
        q.push_back(v);
      end
      run_all();
      force_rdy_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
